// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch-stage next-PC controller.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_e;

    typedef enum logic [2:0] {
        ACT_NONE    = 3'd0,
        ACT_IRQ     = 3'd1,
        ACT_IRET    = 3'd2,
        ACT_REDIR   = 3'd3,
        ACT_STALL   = 3'd4,
        ACT_HLT     = 3'd5,
        ACT_ADV     = 3'd6,
        ACT_LEN_ERR = 3'd7
    } pc_action_e;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] IVT_BASE_DEF  = 32'h0000_0100;

    // Byte offset of a vector entry inside the interrupt vector table.
    function automatic logic [9:0] vec_offset(input logic [7:0] vec);
        return {vec, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch / redirect / interrupt signal bundle around the next-PC controller.
interface pc_sequencer_if #(
    parameter int AW = 32
);
    logic [AW-1:0] pc_out;
    logic          fetch_req;
    logic          fetch_ack;
    logic [3:0]    inst_len;
    logic          stall;
    logic          redir_valid;
    logic [AW-1:0] redir_target;
    logic          irq_req;
    logic [7:0]    irq_vec;
    logic          irq_ack;
    logic          iret;
    logic          sti;
    logic          cli;
    logic          hlt;
    logic [AW-1:0] epc_out;
    logic          ie_out;
    logic          halted;
    logic          len_err;

    modport master (
        output pc_out, fetch_req, irq_ack, epc_out, ie_out, halted, len_err,
        input  fetch_ack, inst_len, stall, redir_valid, redir_target,
               irq_req, irq_vec, iret, sti, cli, hlt
    );

    modport slave (
        input  pc_out, fetch_req, irq_ack, epc_out, ie_out, halted, len_err,
        output fetch_ack, inst_len, stall, redir_valid, redir_target,
               irq_req, irq_vec, iret, sti, cli, hlt
    );
endinterface

// File: rtl/pc_reg.sv
// PC register block: plain AW-bit register that loads RESET_VEC on async reset.
module pc_reg #(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_VEC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_d,
    output logic [AW-1:0] pc_q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_VEC;
        else        pc_q <= pc_d;
    end
endmodule

// File: rtl/pc_sequencer_pc_next_mux.sv
// Combinational priority selector: picks the single PC action for this cycle.
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] IVT_BASE = AW'(IVT_BASE_DEF)
) (
    input  seq_state_e    state,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] epc,
    input  logic          ie,
    input  logic          fetch_ack,
    input  logic [3:0]    inst_len,
    input  logic          stall,
    input  logic          redir_valid,
    input  logic [AW-1:0] redir_target,
    input  logic          irq_req,
    input  logic [7:0]    irq_vec,
    input  logic          iret,
    input  logic          hlt,
    output logic [AW-1:0] pc_nxt,
    output logic [AW-1:0] epc_nxt,
    output pc_action_e    action
);
    logic [AW-1:0] pc_seq;
    logic [AW-1:0] pc_vec;

    assign pc_seq = pc + AW'(inst_len);
    assign pc_vec = IVT_BASE + AW'(vec_offset(irq_vec));

    always_comb begin
        pc_nxt  = pc;
        epc_nxt = epc;
        action  = ACT_NONE;
        case (state)
            RUN: begin
                if (irq_req && ie) begin
                    // a redirect in the same cycle becomes the return address
                    action  = ACT_IRQ;
                    pc_nxt  = pc_vec;
                    epc_nxt = redir_valid ? redir_target : pc;
                end else if (iret) begin
                    action = ACT_IRET;
                    pc_nxt = epc;
                end else if (redir_valid) begin
                    action = ACT_REDIR;
                    pc_nxt = redir_target;
                end else if (stall) begin
                    action = ACT_STALL;
                end else if (hlt && fetch_ack) begin
                    action = ACT_HLT;
                    pc_nxt = pc_seq;
                end else if (fetch_ack) begin
                    if (inst_len == 4'd0) begin
                        action = ACT_LEN_ERR;
                    end else begin
                        action = ACT_ADV;
                        pc_nxt = pc_seq;
                    end
                end
            end
            HALT: begin
                if (irq_req && ie) begin
                    action  = ACT_IRQ;
                    pc_nxt  = pc_vec;
                    epc_nxt = pc;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: BOOT/RUN/HALT FSM, epc and ie registers.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_VEC = AW'(RESET_VEC_DEF),
    parameter logic [AW-1:0] IVT_BASE  = AW'(IVT_BASE_DEF)
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.master bus
);
    seq_state_e    state_q, state_d;
    pc_action_e    action;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] epc_q, epc_d;
    logic          ie_q, ie_d;
    logic          irq_ack_q, irq_ack_d;
    logic          len_err_q, len_err_d;

    pc_next_mux #(.AW(AW), .IVT_BASE(IVT_BASE)) u_mux (
        .state        (state_q),
        .pc           (pc_q),
        .epc          (epc_q),
        .ie           (ie_q),
        .fetch_ack    (bus.fetch_ack),
        .inst_len     (bus.inst_len),
        .stall        (bus.stall),
        .redir_valid  (bus.redir_valid),
        .redir_target (bus.redir_target),
        .irq_req      (bus.irq_req),
        .irq_vec      (bus.irq_vec),
        .iret         (bus.iret),
        .hlt          (bus.hlt),
        .pc_nxt       (pc_d),
        .epc_nxt      (epc_d),
        .action       (action)
    );

    pc_reg #(.AW(AW), .RESET_VEC(RESET_VEC)) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .pc_d  (pc_d),
        .pc_q  (pc_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BOOT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (action == ACT_HLT) state_d = HALT;
            HALT:    if (action == ACT_IRQ) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        bus.fetch_req = 1'b0;
        bus.halted    = 1'b0;
        case (state_q)
            RUN:     bus.fetch_req = 1'b1;
            HALT:    bus.halted    = 1'b1;
            default: ;
        endcase
    end

    // Interrupt entry and iret win over sti/cli; sti with cli is a no-op.
    always_comb begin
        ie_d = ie_q;
        if (action == ACT_IRQ)        ie_d = 1'b0;
        else if (action == ACT_IRET)  ie_d = 1'b1;
        else if (bus.sti && !bus.cli) ie_d = 1'b1;
        else if (bus.cli && !bus.sti) ie_d = 1'b0;
        irq_ack_d = (action == ACT_IRQ);
        len_err_d = (action == ACT_LEN_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_q     <= '0;
            ie_q      <= 1'b0;
            irq_ack_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            epc_q     <= epc_d;
            ie_q      <= ie_d;
            irq_ack_q <= irq_ack_d;
            len_err_q <= len_err_d;
        end
    end

    assign bus.pc_out  = pc_q;
    assign bus.epc_out = epc_q;
    assign bus.ie_out  = ie_q;
    assign bus.irq_ack = irq_ack_q;
    assign bus.len_err = len_err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.AW(32)) bus ();

    pc_sequencer #(.AW(32), .RESET_VEC(32'h0), .IVT_BASE(32'h100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic idle_inputs();
        bus.fetch_ack    = 1'b0;
        bus.inst_len     = 4'd0;
        bus.stall        = 1'b0;
        bus.redir_valid  = 1'b0;
        bus.redir_target = 32'h0;
        bus.irq_req      = 1'b0;
        bus.irq_vec      = 8'h0;
        bus.iret         = 1'b0;
        bus.sti          = 1'b0;
        bus.cli          = 1'b0;
        bus.hlt          = 1'b0;
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        idle_inputs();
        bus.redir_valid  = 1'b1;
        bus.redir_target = tgt;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        vectors++; if (bus.pc_out !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want %h", bus.pc_out, 32'h0); end
        vectors++; if (bus.epc_out !== 32'h0) begin miscompares++; $display("FAIL reset_epc got %h want %h", bus.epc_out, 32'h0); end
        vectors++; if ({bus.ie_out, bus.fetch_req, bus.halted, bus.irq_ack, bus.len_err} !== 5'b0) begin miscompares++; $display("FAIL reset_flags got %b want 00000", {bus.ie_out, bus.fetch_req, bus.halted, bus.irq_ack, bus.len_err}); end
        tick();
        rst_n = 1'b1;
        vectors++; if (bus.fetch_req !== 1'b0) begin miscompares++; $display("FAIL boot_fetch_req got %b want 0", bus.fetch_req); end
        tick();
        vectors++; if (bus.fetch_req !== 1'b1) begin miscompares++; $display("FAIL run_fetch_req got %b want 1", bus.fetch_req); end
        vectors++; if (bus.pc_out !== 32'h0) begin miscompares++; $display("FAIL run_start_pc got %h want %h", bus.pc_out, 32'h0); end
    endtask

    task automatic test_sequential();
        logic [3:0]  lens [3] = '{4'd3, 4'd2, 4'd5};
        logic [31:0] exp  [3] = '{32'h3, 32'h5, 32'hA};
        for (int i = 0; i < 3; i++) begin
            bus.fetch_ack = 1'b1;
            bus.inst_len  = lens[i];
            tick();
            vectors++; if (bus.pc_out !== exp[i]) begin miscompares++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.pc_out, exp[i]); end
        end
        idle_inputs();
        tick();
        vectors++; if (bus.pc_out !== 32'hA) begin miscompares++; $display("FAIL seq_idle_hold got %h want %h", bus.pc_out, 32'hA); end
    endtask

    task automatic test_stall_redirect();
        redirect_to(32'h10);
        vectors++; if (bus.pc_out !== 32'h10) begin miscompares++; $display("FAIL redir_pc got %h want %h", bus.pc_out, 32'h10); end
        bus.stall = 1'b1; bus.fetch_ack = 1'b1; bus.inst_len = 4'd4;
        tick();
        vectors++; if (bus.pc_out !== 32'h10) begin miscompares++; $display("FAIL stall_hold got %h want %h", bus.pc_out, 32'h10); end
        idle_inputs();
        bus.stall = 1'b1; bus.redir_valid = 1'b1; bus.redir_target = 32'h200;
        tick();
        idle_inputs();
        vectors++; if (bus.pc_out !== 32'h200) begin miscompares++; $display("FAIL redir_over_stall got %h want %h", bus.pc_out, 32'h200); end
    endtask

    task automatic test_irq_iret();
        bus.sti = 1'b1;
        tick();
        idle_inputs();
        vectors++; if (bus.ie_out !== 1'b1) begin miscompares++; $display("FAIL sti_ie got %b want 1", bus.ie_out); end
        redirect_to(32'h40);
        bus.irq_req = 1'b1; bus.irq_vec = 8'h03;
        tick();
        vectors++; if (bus.pc_out !== 32'h10C) begin miscompares++; $display("FAIL irq_pc got %h want %h", bus.pc_out, 32'h10C); end
        vectors++; if (bus.epc_out !== 32'h40) begin miscompares++; $display("FAIL irq_epc got %h want %h", bus.epc_out, 32'h40); end
        vectors++; if ({bus.ie_out, bus.irq_ack} !== 2'b01) begin miscompares++; $display("FAIL irq_ie_ack got %b want 01", {bus.ie_out, bus.irq_ack}); end
        tick();
        vectors++; if (bus.irq_ack !== 1'b0) begin miscompares++; $display("FAIL irq_ack_pulse got %b want 0", bus.irq_ack); end
        vectors++; if (bus.pc_out !== 32'h10C) begin miscompares++; $display("FAIL irq_masked_hold got %h want %h", bus.pc_out, 32'h10C); end
        idle_inputs();
        bus.iret = 1'b1; bus.cli = 1'b1;
        tick();
        idle_inputs();
        vectors++; if (bus.pc_out !== 32'h40) begin miscompares++; $display("FAIL iret_pc got %h want %h", bus.pc_out, 32'h40); end
        vectors++; if (bus.ie_out !== 1'b1) begin miscompares++; $display("FAIL iret_ie got %b want 1", bus.ie_out); end
        bus.sti = 1'b1; bus.cli = 1'b1;
        tick();
        vectors++; if (bus.ie_out !== 1'b1) begin miscompares++; $display("FAIL sti_cli_hold got %b want 1", bus.ie_out); end
        idle_inputs();
        bus.cli = 1'b1;
        tick();
        vectors++; if (bus.ie_out !== 1'b0) begin miscompares++; $display("FAIL cli_ie got %b want 0", bus.ie_out); end
        idle_inputs();
        bus.sti = 1'b1;
        tick();
        idle_inputs();
        vectors++; if (bus.ie_out !== 1'b1) begin miscompares++; $display("FAIL sti_again_ie got %b want 1", bus.ie_out); end
    endtask

    task automatic test_irq_redirect();
        bus.redir_valid = 1'b1; bus.redir_target = 32'h300;
        bus.irq_req = 1'b1; bus.irq_vec = 8'h01;
        tick();
        idle_inputs();
        vectors++; if (bus.pc_out !== 32'h104) begin miscompares++; $display("FAIL irq_redir_pc got %h want %h", bus.pc_out, 32'h104); end
        vectors++; if (bus.epc_out !== 32'h300) begin miscompares++; $display("FAIL irq_redir_epc got %h want %h", bus.epc_out, 32'h300); end
        bus.iret = 1'b1;
        tick();
        idle_inputs();
        vectors++; if (bus.pc_out !== 32'h300) begin miscompares++; $display("FAIL iret2_pc got %h want %h", bus.pc_out, 32'h300); end
    endtask

    task automatic test_hlt_wake();
        redirect_to(32'h50);
        bus.hlt = 1'b1; bus.fetch_ack = 1'b1; bus.inst_len = 4'd1;
        tick();
        idle_inputs();
        vectors++; if ({bus.halted, bus.fetch_req} !== 2'b10) begin miscompares++; $display("FAIL hlt_flags got %b want 10", {bus.halted, bus.fetch_req}); end
        vectors++; if (bus.pc_out !== 32'h51) begin miscompares++; $display("FAIL hlt_pc got %h want %h", bus.pc_out, 32'h51); end
        bus.redir_valid = 1'b1; bus.redir_target = 32'h999;
        bus.fetch_ack = 1'b1; bus.inst_len = 4'd4; bus.iret = 1'b1;
        tick();
        idle_inputs();
        vectors++; if (bus.pc_out !== 32'h51) begin miscompares++; $display("FAIL halt_ignore got %h want %h", bus.pc_out, 32'h51); end
        bus.irq_req = 1'b1; bus.irq_vec = 8'h00;
        tick();
        idle_inputs();
        vectors++; if (bus.pc_out !== 32'h100) begin miscompares++; $display("FAIL wake_pc got %h want %h", bus.pc_out, 32'h100); end
        vectors++; if (bus.epc_out !== 32'h51) begin miscompares++; $display("FAIL wake_epc got %h want %h", bus.epc_out, 32'h51); end
        vectors++; if ({bus.halted, bus.fetch_req, bus.ie_out, bus.irq_ack} !== 4'b0101) begin miscompares++; $display("FAIL wake_flags got %b want 0101", {bus.halted, bus.fetch_req, bus.ie_out, bus.irq_ack}); end
    endtask

    task automatic test_wrap_len_err();
        redirect_to(32'hFFFF_FFFE);
        bus.fetch_ack = 1'b1; bus.inst_len = 4'd3;
        tick();
        vectors++; if (bus.pc_out !== 32'h1) begin miscompares++; $display("FAIL wrap_pc got %h want %h", bus.pc_out, 32'h1); end
        bus.inst_len = 4'd0;
        tick();
        idle_inputs();
        vectors++; if (bus.pc_out !== 32'h1) begin miscompares++; $display("FAIL len0_hold got %h want %h", bus.pc_out, 32'h1); end
        vectors++; if (bus.len_err !== 1'b1) begin miscompares++; $display("FAIL len_err_set got %b want 1", bus.len_err); end
        tick();
        vectors++; if (bus.len_err !== 1'b0) begin miscompares++; $display("FAIL len_err_pulse got %b want 0", bus.len_err); end
    endtask

    task automatic test_perm_halt_async_reset();
        bus.hlt = 1'b1; bus.fetch_ack = 1'b1; bus.inst_len = 4'd2;
        tick();
        idle_inputs();
        bus.irq_req = 1'b1; bus.irq_vec = 8'h05;
        tick();
        tick();
        vectors++; if ({bus.halted, bus.irq_ack} !== 2'b10) begin miscompares++; $display("FAIL perm_halt got %b want 10", {bus.halted, bus.irq_ack}); end
        vectors++; if (bus.pc_out !== 32'h3) begin miscompares++; $display("FAIL perm_halt_pc got %h want %h", bus.pc_out, 32'h3); end
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.pc_out !== 32'h0) begin miscompares++; $display("FAIL async_rst_pc got %h want %h", bus.pc_out, 32'h0); end
        vectors++; if (bus.epc_out !== 32'h0) begin miscompares++; $display("FAIL async_rst_epc got %h want %h", bus.epc_out, 32'h0); end
        vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL async_rst_halted got %b want 0", bus.halted); end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++; if (bus.fetch_req !== 1'b1) begin miscompares++; $display("FAIL post_rst_run got %b want 1", bus.fetch_req); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_irq_iret();
        test_irq_redirect();
        test_hlt_wake();
        test_wrap_len_err();
        test_perm_halt_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the CPU fetch stage. It drives the PC register input and sequences PC updates: sequential advance by decoded instruction length, branch/jump redirect, interrupt entry, iret return, stall and HLT.
- Sits between the decoder/execute redirect logic and the instruction-fetch interface.
- Owns the saved return PC (epc) and the interrupt-enable flag.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- IVT_BASE, 32'h0000_0100, interrupt vector table base; target = IVT_BASE + {irq_vec, 2'b00}.
- AW, 32, PC/address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_out  out  AW  current PC (registered), drives fetch address.
- fetch_req  out  1  fetch request for pc_out.
- fetch_ack  in  1  fetch of pc_out complete and decoded this cycle.
- inst_len  in  4  byte length of the instruction at pc_out; valid with fetch_ack.
- stall  in  1  pipeline stall; hold PC.
- redir_valid  in  1  branch taken / jump.
- redir_target  in  AW  redirect target.
- irq_req  in  1  interrupt request, level.
- irq_vec  in  8  interrupt vector number.
- irq_ack  out  1  one-cycle pulse when the interrupt is taken.
- iret  in  1  return from interrupt.
- sti  in  1  set interrupt enable.
- cli  in  1  clear interrupt enable.
- hlt  in  1  HLT executed.
- epc_out  out  AW  saved return PC.
- ie_out  out  1  interrupt-enable flag.
- halted  out  1  high while in HALT.
- len_err  out  1  one-cycle pulse on inst_len==0 with fetch_ack.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc_out=RESET_VEC, epc_out=0, ie_out=0.
  - state=BOOT.
  - fetch_req=0, irq_ack=0, halted=0, len_err=0.
- States: BOOT, RUN, HALT.
- BOOT: one cycle with fetch_req=0, then RUN unconditionally.
- RUN: fetch_req=1. Per-cycle priority, highest first; exactly one action per cycle.
  1. Interrupt: irq_req & ie_out.
     - epc <= (redir_valid ? redir_target : pc_out). The pending redirect is preserved, not lost.
     - pc <= IVT_BASE + {irq_vec, 2'b00}; ie <= 0; irq_ack pulses.
  2. iret: pc <= epc; ie <= 1.
  3. redir_valid: pc <= redir_target.
  4. stall: hold pc. A fetch_ack arriving under stall is ignored; the fetch is re-issued.
  5. hlt & fetch_ack: pc <= pc_out + inst_len; state -> HALT.
  6. fetch_ack:
     - pc <= pc_out + inst_len, modulo 2^AW (wraps silently).
     - If inst_len==0: hold pc and pulse len_err.
  7. Otherwise hold pc.
- HALT:
  - fetch_req=0, halted=1, pc held.
  - Exit to RUN only via interrupt entry (irq_req & ie_out), performing the same actions as item 1 with epc <= pc_out, the instruction after HLT.
  - redir_valid, iret, stall and fetch_ack are ignored in HALT.
  - HLT with ie_out=0 is a permanent halt until reset.
- ie update:
  - Interrupt entry clears ie; iret sets it.
  - Otherwise sti sets and cli clears; sti & cli together leaves ie unchanged.
  - Interrupt entry/iret override sti/cli in the same cycle.
  - A new ie value takes effect for the interrupt check on the next cycle.
- Latency: every PC change is visible on pc_out the cycle after the triggering inputs; there is no combinational path from inputs to pc_out.
- Nested interrupts are not supported (single epc); iret while ie=1 simply reloads epc.
- Reset asserted mid-operation, including in HALT, returns immediately to the reset values above.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum BOOT/RUN/HALT;
  - RESET_VEC and IVT_BASE default constants;
  - the vector-to-address helper function.
- One natural sub-module: pc_next_mux. It is the combinational priority selector producing next-PC and the action code.
- The FSM, epc and ie registers stay in pc_sequencer. The pc register itself is the existing PC register block, instantiated inside.

Test Plan:
- Reset then sequential run: release rst_n; cycle 1 fetch_req=0 (BOOT); fetch_ack with inst_len=3,2,5 -> pc_out 0x0, 0x3, 0x5, 0xA.
- Redirect vs stall: stall=1 with fetch_ack, inst_len=4 -> pc held at 0x10; redir_valid with target 0x200 and stall=1 same cycle -> pc_out=0x200 next cycle.
- Interrupt entry and return: sti, then irq_req, irq_vec=0x03 at pc 0x40 -> pc_out=0x10C, epc=0x40, ie=0, one-cycle irq_ack; iret -> pc_out=0x40, ie=1.
- Interrupt coinciding with redirect: redir_valid to 0x300 plus irq_req, vec 0x01, ie=1 -> pc_out=0x104, epc=0x300.
- HLT wake: hlt & fetch_ack at 0x50, len 1 -> halted=1, fetch_req=0; redir_valid ignored; irq_req vec 0 -> pc_out=0x100, epc=0x51, halted=0.
- Wrap, length error and async reset:
  - pc 0xFFFF_FFFE with len 3 -> pc_out=0x1.
  - fetch_ack with len 0 -> pc held, len_err pulse.
  - rst_n low mid-cycle -> pc_out=RESET_VEC immediately, before the next clock edge.
